// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator, the convolution core and the pooling stages.
package window_gen_3x3_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int IMG_WIDTH_DEF  = 28;
  localparam int IMG_HEIGHT_DEF = 28;

  localparam int WIN_SIZE = 9;

  // Window indices, row-major: top row holds image row r-2, bottom row holds row r.
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  // Smallest image edge for which a full 3x3 neighbourhood exists.
  localparam int MIN_IMG_DIM = 3;

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel stream in, 3x3 window stream out. The master side is the pixel source
// that also consumes the windows; the slave side is the window generator.
interface window_gen_3x3_if #(
  parameter int DATA_WIDTH = window_gen_3x3_pkg::DATA_WIDTH_DEF
) ();
  import window_gen_3x3_pkg::*;

  logic                                 frame_rst;
  logic                                 valid_in;
  logic [DATA_WIDTH-1:0]                data_in;
  logic [WIN_SIZE-1:0][DATA_WIDTH-1:0]  window;
  logic                                 valid_out;
  logic                                 frame_done;

  modport master (
    output frame_rst, valid_in, data_in,
    input  window, valid_out, frame_done
  );

  modport slave (
    input  frame_rst, valid_in, data_in,
    output window, valid_out, frame_done
  );

endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// One image row of storage. Asynchronous read and synchronous write share one
// address, so a read in the writing cycle returns the old entry.
module window_gen_3x3_line_buffer #(
  parameter  int DATA_WIDTH = window_gen_3x3_pkg::DATA_WIDTH_DEF,
  parameter  int DEPTH      = window_gen_3x3_pkg::IMG_WIDTH_DEF,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is left unreset; the window valid gating never exposes stale rows.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Sliding 3x3 window generator: takes raster-order pixels, keeps the two
// previous rows in line buffers and emits a registered 3x3 neighbourhood with
// a one-cycle valid pulse whenever the current pixel has r>=2 and c>=2.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input logic              clk,
  input logic              rst,
  window_gen_3x3_if.slave  bus
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(MIN_IMG_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(MIN_IMG_DIM - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic accept;
  logic at_col_last;
  logic at_row_last;
  logic win_pos;

  logic [DATA_WIDTH-1:0] lb0_rd;
  logic [DATA_WIDTH-1:0] lb1_rd;

  logic [WIN_SIZE-1:0][DATA_WIDTH-1:0] win_q;
  logic                                valid_q;
  logic                                done_q;

  // A frame restart in the same cycle drops the pixel.
  assign accept      = bus.valid_in && !bus.frame_rst;
  assign at_col_last = (col == COL_LAST);
  assign at_row_last = (row == ROW_LAST);
  assign win_pos     = (row >= ROW_FIRST) && (col >= COL_FIRST);

  // lb0 holds row r-1; lb1 takes the entry lb0 is about to overwrite, so it holds row r-2.
  window_gen_3x3_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) lb0 (
    .clk     (clk),
    .addr    (col),
    .wr_en   (accept),
    .wr_data (bus.data_in),
    .rd_data (lb0_rd)
  );

  window_gen_3x3_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) lb1 (
    .clk     (clk),
    .addr    (col),
    .wr_en   (accept),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Raster position of the next pixel; wraps straight into the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.frame_rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_col_last) begin
        col <= '0;
        row <= at_row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Shift the window left and load the new right column from the line buffers and input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q <= '0;
    end else if (accept) begin
      win_q[WIN_TL] <= win_q[WIN_TC];
      win_q[WIN_TC] <= win_q[WIN_TR];
      win_q[WIN_TR] <= lb1_rd;
      win_q[WIN_ML] <= win_q[WIN_MC];
      win_q[WIN_MC] <= win_q[WIN_MR];
      win_q[WIN_MR] <= lb0_rd;
      win_q[WIN_BL] <= win_q[WIN_BC];
      win_q[WIN_BC] <= win_q[WIN_BR];
      win_q[WIN_BR] <= bus.data_in;
    end
  end

  // Flag only windows lying fully inside the current frame; frame_rst and idle clear both pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= accept && win_pos;
      done_q  <= accept && at_col_last && at_row_last;
    end
  end

  assign bus.window     = win_q;
  assign bus.valid_out  = valid_q;
  assign bus.frame_done = done_q;

endmodule
